// File: rtl/write_back_buffer.sv
// Write-back buffer: coalescing eviction FIFO between the cache and data RAM.
// Drains buffered words to memory and serves refills, forwarding buffered data.
module write_back_buffer #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 32,
   parameter int DEPTH      = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  evict_we,
   input  logic [ADDR_WIDTH-1:0] evict_addr,
   input  logic [DATA_WIDTH-1:0] evict_wd,
   input  logic                  rd_req,
   input  logic [ADDR_WIDTH-1:0] rd_addr,
   output logic [DATA_WIDTH-1:0] rd_data,
   output logic                  rd_valid,
   output logic                  stall,
   output logic                  mem_req,
   output logic                  mem_we,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0] mem_wd,
   input  logic                  mem_ack,
   input  logic [DATA_WIDTH-1:0] mem_rd
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   typedef enum logic [1:0] {
      S_IDLE,
      S_READ,
      S_DRAIN
   } state_t;

   state_t r_state;
   state_t w_state_nxt;

   logic [DEPTH-1:0]      r_vld;
   logic [ADDR_WIDTH-1:0] r_addr [DEPTH];
   logic [DATA_WIDTH-1:0] r_data [DEPTH];
   logic [PW-1:0]         r_head;
   logic [PW-1:0]         r_tail;
   logic [CW-1:0]         r_count;

   logic                  r_rd_valid;
   logic [DATA_WIDTH-1:0] r_rd_data;
   logic                  r_mem_req;
   logic                  r_mem_we;
   logic [ADDR_WIDTH-1:0] r_mem_addr;
   logic [DATA_WIDTH-1:0] r_mem_wd;

   logic                  w_rd_valid_nxt;
   logic [DATA_WIDTH-1:0] w_rd_data_nxt;
   logic                  w_mem_req_nxt;
   logic                  w_mem_we_nxt;
   logic [ADDR_WIDTH-1:0] w_mem_addr_nxt;
   logic [DATA_WIDTH-1:0] w_mem_wd_nxt;

   logic                  w_full;
   logic                  w_coal_hit;
   logic [PW-1:0]         w_coal_idx;
   logic                  w_coal;
   logic                  w_app;
   logic                  w_acc;
   logic                  w_drain_done;
   logic                  w_rd_go;
   logic                  w_fwd_hit;
   logic [DATA_WIDTH-1:0] w_fwd_data;
   logic [PW-1:0]         w_fwd_idx;
   logic [DATA_WIDTH-1:0] w_head_data;

   assign w_full = (r_count == CW'(DEPTH));

   // The head entry being written to memory cannot absorb new data.
   always_comb begin
      w_coal_hit = 1'b0;
      w_coal_idx = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (r_vld[i] && (r_addr[i] == evict_addr) &&
             !((r_state == S_DRAIN) && (PW'(i) == r_head))) begin
            w_coal_hit = 1'b1;
            w_coal_idx = PW'(i);
         end
      end
   end

   assign w_coal       = evict_we && w_coal_hit;
   assign w_app        = evict_we && !w_coal_hit && !w_full;
   assign w_acc        = w_coal || w_app;
   assign stall        = evict_we && !w_coal_hit && w_full;
   assign w_drain_done = (r_state == S_DRAIN) && r_mem_req && mem_ack;
   assign w_rd_go      = rd_req && !r_rd_valid;

   // Walk oldest to youngest so the youngest match wins.
   always_comb begin
      w_fwd_hit  = 1'b0;
      w_fwd_data = '0;
      w_fwd_idx  = '0;
      for (int k = 0; k < DEPTH; k++) begin
         w_fwd_idx = r_head + PW'(k);
         if (r_vld[w_fwd_idx] && (r_addr[w_fwd_idx] == rd_addr)) begin
            w_fwd_hit  = 1'b1;
            w_fwd_data = r_data[w_fwd_idx];
         end
      end
      if (w_acc && (evict_addr == rd_addr)) begin
         w_fwd_hit  = 1'b1;
         w_fwd_data = evict_wd;
      end
   end

   // A coalesce into the head on the launch cycle must reach memory.
   assign w_head_data = (w_coal && (w_coal_idx == r_head)) ?
                        evict_wd : r_data[r_head];

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state    <= S_IDLE;
         r_rd_valid <= 1'b0;
         r_rd_data  <= '0;
         r_mem_req  <= 1'b0;
         r_mem_we   <= 1'b0;
         r_mem_addr <= '0;
         r_mem_wd   <= '0;
      end else begin
         r_state    <= w_state_nxt;
         r_rd_valid <= w_rd_valid_nxt;
         r_rd_data  <= w_rd_data_nxt;
         r_mem_req  <= w_mem_req_nxt;
         r_mem_we   <= w_mem_we_nxt;
         r_mem_addr <= w_mem_addr_nxt;
         r_mem_wd   <= w_mem_wd_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         S_IDLE: begin
            if (w_rd_go) begin
               if (!w_fwd_hit) begin
                  w_state_nxt = S_READ;
               end
            end else if (r_count != '0) begin
               w_state_nxt = S_DRAIN;
            end
         end
         S_READ: begin
            if (mem_ack) begin
               w_state_nxt = S_IDLE;
            end
         end
         S_DRAIN: begin
            if (mem_ack) begin
               w_state_nxt = S_IDLE;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      w_rd_valid_nxt = 1'b0;
      w_rd_data_nxt  = r_rd_data;
      w_mem_req_nxt  = r_mem_req;
      w_mem_we_nxt   = r_mem_we;
      w_mem_addr_nxt = r_mem_addr;
      w_mem_wd_nxt   = r_mem_wd;
      unique case (r_state)
         S_IDLE: begin
            if (w_rd_go && w_fwd_hit) begin
               w_rd_valid_nxt = 1'b1;
               w_rd_data_nxt  = w_fwd_data;
            end else if (w_rd_go) begin
               w_mem_req_nxt  = 1'b1;
               w_mem_we_nxt   = 1'b0;
               w_mem_addr_nxt = rd_addr;
            end else if (r_count != '0) begin
               w_mem_req_nxt  = 1'b1;
               w_mem_we_nxt   = 1'b1;
               w_mem_addr_nxt = r_addr[r_head];
               w_mem_wd_nxt   = w_head_data;
            end
         end
         S_READ: begin
            if (mem_ack) begin
               w_rd_valid_nxt = 1'b1;
               w_rd_data_nxt  = mem_rd;
               w_mem_req_nxt  = 1'b0;
            end
         end
         S_DRAIN: begin
            if (mem_ack) begin
               w_mem_req_nxt = 1'b0;
            end
         end
         default: w_mem_req_nxt = 1'b0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_vld   <= '0;
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            r_addr[i] <= '0;
            r_data[i] <= '0;
         end
      end else begin
         if (w_coal) begin
            r_data[w_coal_idx] <= evict_wd;
         end
         if (w_app) begin
            r_vld[r_tail]  <= 1'b1;
            r_addr[r_tail] <= evict_addr;
            r_data[r_tail] <= evict_wd;
            r_tail         <= r_tail + 1'b1;
         end
         if (w_drain_done) begin
            r_vld[r_head] <= 1'b0;
            r_head        <= r_head + 1'b1;
         end
         r_count <= r_count + CW'(w_app) - CW'(w_drain_done);
      end
   end

   assign rd_valid = r_rd_valid;
   assign rd_data  = r_rd_data;
   assign mem_req  = r_mem_req;
   assign mem_we   = r_mem_we;
   assign mem_addr = r_mem_addr;
   assign mem_wd   = r_mem_wd;

endmodule
